pwm_dac: RTL and testbench

Sample-consuming end of the audio sample path: a pulse-width-modulation DAC that pulls samples from an upstream generator (such as `sq_wave_gen`) once per PWM window via a single-cycle `next_sample` request. It turns each returned `code` into the duty cycle of a 1-bit output that drives the board audio pin. The block owns the sample-rate timebase: the generator only advances when this block asks.

---
 rtl/pwm_dac_if.sv | 28 ++
 rtl/pwm_dac.sv | 99 +++++++++
 tb/tb_pwm_dac.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_dac_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_dac_if
//  Purpose  : Sample request/data link between the PWM DAC (sample consumer)
//             and an upstream code generator.
//  Signals  : code        - unsigned sample code, driven by the generator
//             next_sample - single-cycle advance request, driven by the DAC
//  Modports : master - DAC side (issues requests, consumes code)
//             slave  - generator side (supplies code, receives requests)
//  Revision : 1.0 - initial release
// ============================================================================
interface pwm_dac_if #(
    parameter int CODE_WIDTH = 10
);
    logic [CODE_WIDTH-1:0] code;
    logic                  next_sample;

    modport master (
        input  code,
        output next_sample
    );

    modport slave (
        output code,
        input  next_sample
    );
endinterface
`default_nettype wire

// File: rtl/pwm_dac.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_dac
//  Purpose  : Pulse-width-modulation DAC. Owns the sample-rate timebase:
//             every CYCLES_PER_WINDOW clocks it requests one new code from
//             the upstream generator and turns it into the duty cycle of a
//             1-bit output.
//  Ports    : clk  - system clock
//             rst  - synchronous active-high reset
//             en   - run enable; low mutes the output and stops requests
//             smp  - pwm_dac_if.master (code in, next_sample out)
//             pwm  - PWM output to the audio pin
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_dac #(
    parameter int CYCLES_PER_WINDOW = 1024,
    parameter int CODE_WIDTH        = 10
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        en,
    pwm_dac_if.master        smp,
    output logic             pwm
);

    localparam int c_CNT_W  = $clog2(CYCLES_PER_WINDOW);
    localparam int c_DUTY_W = c_CNT_W + 1;
    // Saturation compare is done wide enough to hold both the raw code and
    // the full-scale value, so no code bit is ever truncated.
    localparam int c_CMP_W  = (CODE_WIDTH > c_DUTY_W) ? CODE_WIDTH : c_DUTY_W;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CYCLES_PER_WINDOW - 1);
    localparam logic [c_CMP_W-1:0] c_FULL     = c_CMP_W'(CYCLES_PER_WINDOW);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_DUTY_W-1:0]  r_duty;

    logic                 w_last;
    logic [c_CMP_W-1:0]   w_code_ext;
    logic [c_CMP_W-1:0]   w_sat;
    logic [c_DUTY_W-1:0]  w_sat_duty;

    assign w_last     = (r_cnt == c_CNT_LAST);
    assign w_code_ext = c_CMP_W'(smp.code);
    assign w_sat      = (w_code_ext >= c_FULL) ? c_FULL : w_code_ext;
    assign w_sat_duty = w_sat[c_DUTY_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_duty  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (en) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        // The request has already gone out this cycle and the
                        // generator advances on this edge, so the code is
                        // always captured here to keep the handshake one-for-
                        // one, even if en drops in the same cycle.
                        r_cnt  <= '0;
                        r_duty <= w_sat_duty;
                        if (!en) begin
                            r_state <= S_IDLE;
                        end
                    end else if (!en) begin
                        // Partial window is abandoned: no request, no load.
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs decode registers only; no path from code or en.
    assign smp.next_sample = (r_state == S_RUN) && w_last;
    assign pwm             = (r_state == S_RUN) && ({1'b0, r_cnt} < r_duty);

endmodule
`default_nettype wire

// File: tb/tb_pwm_dac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_dac
//  Purpose  : Self-checking bench for pwm_dac. Three instances:
//             A - default window (1024), B - 1000-cycle window (saturation),
//             C - 16-cycle window driven by a generator model (closed loop).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_dac;

    logic clk;
    logic rst_a, en_a, pwm_a;
    logic rst_b, en_b, pwm_b;
    logic rst_c, en_c, pwm_c;

    int n_checks = 0;
    int n_errors = 0;

    pwm_dac_if #(.CODE_WIDTH(10)) bus_a ();
    pwm_dac_if #(.CODE_WIDTH(10)) bus_b ();
    pwm_dac_if #(.CODE_WIDTH(5))  bus_c ();

    pwm_dac #(.CYCLES_PER_WINDOW(1024), .CODE_WIDTH(10)) u_dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .smp(bus_a), .pwm(pwm_a)
    );
    pwm_dac #(.CYCLES_PER_WINDOW(1000), .CODE_WIDTH(10)) u_dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .smp(bus_b), .pwm(pwm_b)
    );
    pwm_dac #(.CYCLES_PER_WINDOW(16), .CODE_WIDTH(5)) u_dut_c (
        .clk(clk), .rst(rst_c), .en(en_c), .smp(bus_c), .pwm(pwm_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    // Reference rule: duty = min(code, window length).
    function automatic int sat(input int c, input int n);
        return (c < n) ? c : n;
    endfunction

    task automatic set_code(input int which, input int val);
        case (which)
            0:       bus_a.code = 10'(val);
            1:       bus_b.code = 10'(val);
            default: bus_c.code = 5'(val);
        endcase
    endtask

    // Measures n consecutive cycles (sampled on falling edges) of one DUT.
    // Optionally changes its code after sampling position chg_pos.
    task automatic observe(input int which, input int n, input int chg_pos, input int chg_code,
                           output int high_cnt, output int max_high,
                           output int ns_cnt, output int ns_last);
        logic pw, ns;
        high_cnt = 0; max_high = -1; ns_cnt = 0; ns_last = -1;
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            case (which)
                0:       begin pw = pwm_a; ns = bus_a.next_sample; end
                1:       begin pw = pwm_b; ns = bus_b.next_sample; end
                default: begin pw = pwm_c; ns = bus_c.next_sample; end
            endcase
            if (pw === 1'b1) begin high_cnt++; max_high = p; end
            if (ns === 1'b1) begin ns_cnt++;   ns_last  = p; end
            if (p == chg_pos) set_code(which, chg_code);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int hc, mh, nc, nl;
        rst_a = 1'b1; en_a = 1'b1; set_code(0, 512);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (pwm_a !== 1'b0) begin n_errors++; $display("FAIL reset_pwm c%0d: got %b, expected 0", i, pwm_a); end
            n_checks++;
            if (bus_a.next_sample !== 1'b0) begin n_errors++; $display("FAIL reset_ns c%0d: got %b, expected 0", i, bus_a.next_sample); end
        end
        rst_a = 1'b0;
        observe(0, 1024, -1, 0, hc, mh, nc, nl);
        n_checks++;
        if (hc !== 0) begin n_errors++; $display("FAIL first_window_high: got %0d, expected 0", hc); end
        n_checks++;
        if (nc !== 1 || nl !== 1023) begin n_errors++; $display("FAIL first_window_ns: got %0d pulses last at %0d, expected 1 at 1023", nc, nl); end
    endtask

    task automatic test_half_scale();
        int hc, mh, nc, nl;
        for (int w = 0; w < 2; w++) begin
            observe(0, 1024, -1, 0, hc, mh, nc, nl);
            n_checks++;
            if (hc !== 512 || mh !== 511) begin n_errors++; $display("FAIL half_shape w%0d: got %0d high last %0d, expected 512 high last 511", w, hc, mh); end
            n_checks++;
            if (nc !== 1 || nl !== 1023) begin n_errors++; $display("FAIL half_ns w%0d: got %0d pulses at %0d, expected 1 at 1023", w, nc, nl); end
        end
    endtask

    task automatic test_boundary();
        int hc, mh, nc, nl, c, e;
        int codes[4];
        codes[0] = 0; codes[1] = 1023;
        codes[2] = $urandom_range(1, 1022); codes[3] = $urandom_range(1, 1022);
        for (int k = 0; k < 4; k++) begin
            c = codes[k];
            set_code(0, c);
            e = sat(c, 1024);
            observe(0, 1024, -1, 0, hc, mh, nc, nl);
            n_checks++;
            if (hc !== e || mh !== e - 1) begin n_errors++; $display("FAIL boundary code=%0d: got %0d high last %0d, expected %0d high", c, hc, mh, e); end
            n_checks++;
            if (nc !== 1 || nl !== 1023) begin n_errors++; $display("FAIL boundary_ns code=%0d: got %0d pulses at %0d, expected 1 at 1023", c, nc, nl); end
        end
    endtask

    task automatic test_mid_window();
        int hc, mh, nc, nl;
        set_code(0, 100);
        observe(0, 1024, 50, 900, hc, mh, nc, nl);
        n_checks++;
        if (hc !== 100 || mh !== 99) begin n_errors++; $display("FAIL mid_change_current: got %0d high, expected 100", hc); end
        observe(0, 1024, -1, 0, hc, mh, nc, nl);
        n_checks++;
        if (hc !== 900 || mh !== 899) begin n_errors++; $display("FAIL mid_change_next: got %0d high, expected 900", hc); end
    endtask

    task automatic test_enable_gap();
        int hc, mh, nc, nl, r1, r2, gap_hi, gap_ns;
        r1 = $urandom_range(1, 1023);
        r2 = $urandom_range(1, 1023);
        if (r2 == r1) r2 = (r1 % 1023) + 1;
        set_code(0, r1);
        observe(0, 301, -1, 0, hc, mh, nc, nl);
        n_checks++;
        if (hc !== sat(r1, 301) || nc !== 0) begin n_errors++; $display("FAIL en_partial: got %0d high %0d pulses, expected %0d high 0 pulses", hc, nc, sat(r1, 301)); end
        en_a = 1'b0;
        set_code(0, r2);
        gap_hi = 0; gap_ns = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pwm_a !== 1'b0) gap_hi++;
            if (bus_a.next_sample !== 1'b0) gap_ns++;
        end
        n_checks++;
        if (gap_hi !== 0) begin n_errors++; $display("FAIL en_gap_pwm: got %0d non-low cycles, expected 0", gap_hi); end
        n_checks++;
        if (gap_ns !== 0) begin n_errors++; $display("FAIL en_gap_ns: got %0d non-low cycles, expected 0", gap_ns); end
        en_a = 1'b1;
        observe(0, 1024, -1, 0, hc, mh, nc, nl);
        n_checks++;
        if (hc !== r1 || mh !== r1 - 1) begin n_errors++; $display("FAIL en_retained_duty: got %0d high, expected %0d", hc, r1); end
        n_checks++;
        if (nc !== 1 || nl !== 1023) begin n_errors++; $display("FAIL en_restart_ns: got %0d pulses at %0d, expected 1 at 1023", nc, nl); end
        observe(0, 1024, -1, 0, hc, mh, nc, nl);
        n_checks++;
        if (hc !== r2) begin n_errors++; $display("FAIL en_after_gap_load: got %0d high, expected %0d", hc, r2); end
    endtask

    task automatic test_reset_mid();
        int hc, mh, nc, nl, r2;
        r2 = 777;
        set_code(0, r2);
        observe(0, 1024, -1, 0, hc, mh, nc, nl);
        observe(0, 601, -1, 0, hc, mh, nc, nl);
        n_checks++;
        if (hc !== 601) begin n_errors++; $display("FAIL rst_pre_window: got %0d high, expected 601", hc); end
        rst_a = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pwm_a !== 1'b0 || bus_a.next_sample !== 1'b0) begin n_errors++; $display("FAIL rst_mid_outputs: got pwm=%b ns=%b, expected 0 0", pwm_a, bus_a.next_sample); end
        rst_a = 1'b0;
        observe(0, 1024, -1, 0, hc, mh, nc, nl);
        n_checks++;
        if (hc !== 0) begin n_errors++; $display("FAIL rst_mid_duty_zero: got %0d high, expected 0", hc); end
        n_checks++;
        if (nc !== 1 || nl !== 1023) begin n_errors++; $display("FAIL rst_mid_ns: got %0d pulses at %0d, expected 1 at 1023", nc, nl); end
        observe(0, 1024, -1, 0, hc, mh, nc, nl);
        n_checks++;
        if (hc !== r2) begin n_errors++; $display("FAIL rst_mid_reload: got %0d high, expected %0d", hc, r2); end
    endtask

    task automatic test_saturation();
        int hc, mh, nc, nl, e;
        int codes[4];
        codes[0] = 1023; codes[1] = 1000; codes[2] = 999; codes[3] = 0;
        set_code(1, codes[0]); en_b = 1'b1; rst_b = 1'b0;
        observe(1, 1000, -1, 0, hc, mh, nc, nl);
        n_checks++;
        if (hc !== 0 || nc !== 1 || nl !== 999) begin n_errors++; $display("FAIL sat_first: got %0d high %0d pulses at %0d, expected 0 high 1 at 999", hc, nc, nl); end
        for (int k = 0; k < 4; k++) begin
            set_code(1, codes[k]);
            e = sat(codes[k], 1000);
            observe(1, 1000, -1, 0, hc, mh, nc, nl);
            n_checks++;
            if (hc !== e || mh !== e - 1) begin n_errors++; $display("FAIL sat code=%0d: got %0d high last %0d, expected %0d high", codes[k], hc, mh, e); end
            n_checks++;
            if (nc !== 1 || nl !== 999) begin n_errors++; $display("FAIL sat_ns code=%0d: got %0d pulses at %0d, expected 1 at 999", codes[k], nc, nl); end
        end
    endtask

    // Generator model: holds seq[gi] and advances on the edge that ends a
    // request cycle. Window w (w>=1) must show min(seq[w-1], 16) high cycles.
    task automatic test_closed_loop();
        int seq[201];
        int gi, hc, nc, nl, e;
        for (int i = 0; i < 201; i++) seq[i] = $urandom_range(0, 31);
        gi = 0;
        set_code(2, seq[0]); en_c = 1'b1; rst_c = 1'b0;
        for (int w = 0; w <= 200; w++) begin
            hc = 0; nc = 0; nl = -1;
            for (int p = 0; p < 16; p++) begin
                @(negedge clk);
                if (pwm_c === 1'b1) hc++;
                if (bus_c.next_sample === 1'b1) begin nc++; nl = p; end
            end
            if (bus_c.next_sample === 1'b1) begin
                @(posedge clk);
                #1;
                if (gi < 200) gi++;
                set_code(2, seq[gi]);
            end
            e = (w == 0) ? 0 : sat(seq[w - 1], 16);
            n_checks++;
            if (hc !== e) begin n_errors++; $display("FAIL loop_high w%0d: got %0d, expected %0d", w, hc, e); end
            n_checks++;
            if (nc !== 1 || nl !== 15) begin n_errors++; $display("FAIL loop_ns w%0d: got %0d pulses at %0d, expected 1 at 15", w, nc, nl); end
        end
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; bus_a.code = '0;
        rst_b = 1'b1; en_b = 1'b0; bus_b.code = '0;
        rst_c = 1'b1; en_c = 1'b0; bus_c.code = '0;
        test_reset();
        test_half_scale();
        test_boundary();
        test_mid_window();
        test_enable_gap();
        test_reset_mid();
        test_saturation();
        test_closed_loop();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
